hdmi_video_ctrl: RTL
====================

Name: hdmi_video_ctrl

Overview:
- Sequences the TMDS transmitter: generates raster timing, issues pixel fetch requests to a pixel source, and aligns the returned colour with DE and sync.
- Drives the transmitter's i_de, i_data_ch0..2 and i_ctrl_ch0..2 directly, in the pixel clock domain.
- Start and stop are gated to frame boundaries. Pixel-source underflow is detected and reported.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- H_POL, 0, asserted hsync level
- V_POL, 0, asserted vsync level
- PIX_LAT, 2, fixed source latency in cycles from o_req to i_rgb/i_rgb_valid (range 1..8)
- UNDERFLOW_RGB, 24'hFF00FF, colour substituted on underflow

Ports:
- i_pix_clk  in  1  pixel clock
- i_rst_n  in  1  synchronous active-low reset
- i_enable  in  1  run request
- o_busy  out  1  state != IDLE
- o_frame_start  out  1  one-cycle pulse when counters are at (0,0) in RUN
- o_req  out  1  pixel fetch request
- o_req_x  out  12  column of the requested pixel
- o_req_y  out  12  row of the requested pixel
- i_rgb  in  24  {R,G,B} returned pixel
- i_rgb_valid  in  1  i_rgb valid
- o_de  out  1  display enable
- o_data_ch0  out  8  blue
- o_data_ch1  out  8  green
- o_data_ch2  out  8  red
- o_ctrl_ch0  out  2  {vsync, hsync}
- o_ctrl_ch1  out  2  constant 0
- o_ctrl_ch2  out  2  constant 0
- o_underflow  out  1  sticky underflow flag
- i_clr_underflow  in  1  clears o_underflow

Behaviour:
- Reset: state IDLE; h=v=0; all delay-line stages hold DE=0 with sync deasserted.
  - Outputs: o_de=0, o_data=0, o_ctrl_ch0={~V_POL,~H_POL}, o_req=0, o_busy=0, o_frame_start=0, o_underflow=0.
  - Reset asserted mid-frame aborts the frame; these values appear on the next edge.
- Totals: H_TOTAL = sum of H parameters; V_TOTAL = sum of V parameters; both ≤ 4096.
- Counters:
  - h counts 0..H_TOTAL-1, then wraps to 0 and v increments.
  - v wraps to 0 after V_TOTAL-1.
- Region decode, from the counter registers in the same cycle:
  - active = h<H_ACTIVE && v<V_ACTIVE
  - hs = H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (whole lines)
- Requests: o_req = active && state != IDLE; o_req_x = h; o_req_y = v.
- FSM:
  - IDLE: counters held at 0. i_enable=1 → RUN, counting starts next cycle.
  - RUN: i_enable=0 → DRAIN.
  - DRAIN: counting continues. i_enable=1 → RUN with no gap. At h=H_TOTAL-1, v=V_TOTAL-1 → IDLE, counters return to 0.
- Alignment: active, hs and vs pass through a PIX_LAT-deep delay line, then an output register stage.
  - o_de asserts exactly PIX_LAT+1 cycles after the matching o_req.
  - o_data is captured from i_rgb in the same cycle the delayed active bit is registered.
- Blanking: when delayed active=0, o_data=0. i_rgb_valid is ignored and is not an error.
- Sync encoding: o_ctrl_ch0[0] = hs ? H_POL : ~H_POL; o_ctrl_ch0[1] = vs ? V_POL : ~V_POL.
- Underflow: delayed active=1 with i_rgb_valid=0 → o_data=UNDERFLOW_RGB, and o_underflow sets on the same edge.
  - o_underflow is sticky.
  - i_clr_underflow clears it; if set and clear coincide, set wins.
- The delay line keeps flushing after entering IDLE. Sync deasserts with its normal timing because the frame ended in blanking.

Decomposition:
- Package hdmi_video_pkg: timing constant sets for 640x480@60 and 1280x720@60, CTRL encoding, FSM state enum (IDLE, RUN, DRAIN).
- Sub-module video_timing_counter: h/v counters, wrap logic and active/hs/vs decode, with an enable input.
- Delay line, output register stage and FSM live in the top module.

Test Plan:
- Reset → o_ctrl_ch0=2'b11, o_de=0, o_data=0, o_busy=0.
- Reset released, then i_enable=1 with default parameters:
  - o_req high 640 cycles/line for 480 lines.
  - hsync low 96 cycles starting at h=656.
  - vsync low on v=490..491.
  - o_frame_start period 420000 cycles.
- Source model with PIX_LAT=2 returning rgb={x[7:0],y[7:0],8'h5A} →
  - first o_de exactly 3 cycles after the first o_req, with ch0=8'h5A, ch1=y, ch2=x.
  - 640 consecutive DE cycles per line.
- Source withholds valid for pixel (100,5) → that output is R=FF G=00 B=FF, o_underflow=1 and held; i_clr_underflow pulse → 0; coincident set and clear → 1.
- i_enable dropped at v=100 → frame completes, o_busy falls after (799,524); separate run re-raising i_enable during DRAIN → uninterrupted next frame start.
- i_rst_n low during active video → next cycle o_de=0, o_ctrl_ch0=2'b11, o_busy=0, counters at 0.

Source files
------------

// File: rtl/hdmi_video_pkg.sv
// Timing sets, TMDS control-symbol sync encoding and FSM state type for the HDMI video controller.
// Combinational helpers only; no latency, no backpressure.
package hdmi_video_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int   VGA_H_ACTIVE = 640;
  localparam int   VGA_H_FP     = 16;
  localparam int   VGA_H_SYNC   = 96;
  localparam int   VGA_H_BP     = 48;
  localparam int   VGA_V_ACTIVE = 480;
  localparam int   VGA_V_FP     = 10;
  localparam int   VGA_V_SYNC   = 2;
  localparam int   VGA_V_BP     = 33;
  localparam logic VGA_H_POL    = 1'b0;
  localparam logic VGA_V_POL    = 1'b0;

  // 1280x720@60, 74.25 MHz pixel clock
  localparam int   HD_H_ACTIVE  = 1280;
  localparam int   HD_H_FP      = 110;
  localparam int   HD_H_SYNC    = 40;
  localparam int   HD_H_BP      = 220;
  localparam int   HD_V_ACTIVE  = 720;
  localparam int   HD_V_FP      = 5;
  localparam int   HD_V_SYNC    = 5;
  localparam int   HD_V_BP      = 20;
  localparam logic HD_H_POL     = 1'b1;
  localparam logic HD_V_POL     = 1'b1;

  // Channel-0 control pair is {vsync, hsync}; each pin idles at the inverse of its asserted level.
  function automatic logic [1:0] ctrl_enc(input logic vs, input logic hs,
                                          input logic v_pol, input logic h_pol);
    return {vs ? v_pol : ~v_pol, hs ? h_pol : ~h_pol};
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster h/v position counters with active/hsync/vsync decode; decode is combinational from the count registers.
// Advances one pixel per cycle while en is high, holds otherwise; no backpressure.
module video_timing_counter
  import hdmi_video_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [11:0] h,
  output logic [11:0] v,
  output logic        active,
  output logic        hs,
  output logic        vs,
  output logic        last
);

  localparam int          H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
  // 13-bit bounds so a total of exactly 4096 still decodes correctly
  localparam logic [12:0] H_ACT   = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT   = 13'(V_ACTIVE);
  localparam logic [12:0] HS_BEG  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END  = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_BEG  = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END  = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic [12:0] h_x, v_x;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (en) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 12'd1;
      end else begin
        h <= h + 12'd1;
      end
    end
  end

  assign h_x    = {1'b0, h};
  assign v_x    = {1'b0, v};
  assign active = (h_x < H_ACT) && (v_x < V_ACT);
  assign hs     = (h_x >= HS_BEG) && (h_x < HS_END);
  assign vs     = (v_x >= VS_BEG) && (v_x < VS_END);
  assign last   = (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/hdmi_video_ctrl.sv
// Raster sequencer for the TMDS transmitter: fetch requests out, colour/DE/sync aligned PIX_LAT+1 cycles later.
// Source has fixed latency and no backpressure; a missing valid in active video substitutes UNDERFLOW_RGB and sets a sticky flag.
module hdmi_video_ctrl
  import hdmi_video_pkg::*;
#(
  parameter int          H_ACTIVE      = VGA_H_ACTIVE,
  parameter int          H_FP          = VGA_H_FP,
  parameter int          H_SYNC        = VGA_H_SYNC,
  parameter int          H_BP          = VGA_H_BP,
  parameter int          V_ACTIVE      = VGA_V_ACTIVE,
  parameter int          V_FP          = VGA_V_FP,
  parameter int          V_SYNC        = VGA_V_SYNC,
  parameter int          V_BP          = VGA_V_BP,
  parameter logic        H_POL         = VGA_H_POL,
  parameter logic        V_POL         = VGA_V_POL,
  parameter int          PIX_LAT       = 2,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic        i_pix_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  output logic        o_busy,
  output logic        o_frame_start,
  output logic        o_req,
  output logic [11:0] o_req_x,
  output logic [11:0] o_req_y,
  input  logic [23:0] i_rgb,
  input  logic        i_rgb_valid,
  output logic        o_de,
  output logic [7:0]  o_data_ch0,
  output logic [7:0]  o_data_ch1,
  output logic [7:0]  o_data_ch2,
  output logic [1:0]  o_ctrl_ch0,
  output logic [1:0]  o_ctrl_ch1,
  output logic [1:0]  o_ctrl_ch2,
  output logic        o_underflow,
  input  logic        i_clr_underflow
);

  state_t       state, state_nx;
  logic         cnt_en;
  logic [11:0]  h, v;
  logic         active, hs, vs, last;
  logic [PIX_LAT-1:0] dl_de, dl_hs, dl_vs;
  logic         de_d, hs_d, vs_d;
  logic [23:0]  rgb_q;

  assign cnt_en = (state != IDLE);

  video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk    (i_pix_clk),
    .rst_n  (i_rst_n),
    .en     (cnt_en),
    .h      (h),
    .v      (v),
    .active (active),
    .hs     (hs),
    .vs     (vs),
    .last   (last)
  );

  always_ff @(posedge i_pix_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Stopping only takes effect at the end of a frame; re-enabling in DRAIN resumes without a gap.
  always_comb begin
    state_nx      = state;
    o_busy        = (state != IDLE);
    o_req         = active && (state != IDLE);
    o_frame_start = (state == RUN) && (h == 12'd0) && (v == 12'd0);
    case (state)
      IDLE:    if (i_enable) state_nx = RUN;
      RUN:     if (!i_enable) state_nx = DRAIN;
      DRAIN: begin
        if (i_enable)  state_nx = RUN;
        else if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign o_req_x = h;
  assign o_req_y = v;

  // The request (not raw active) is delayed, so an idle controller parked at (0,0) never raises DE.
  always_ff @(posedge i_pix_clk) begin
    if (!i_rst_n) begin
      dl_de <= '0;
      dl_hs <= '0;
      dl_vs <= '0;
    end else begin
      dl_de[0] <= o_req;
      dl_hs[0] <= hs;
      dl_vs[0] <= vs;
      for (int i = 1; i < PIX_LAT; i++) begin
        dl_de[i] <= dl_de[i-1];
        dl_hs[i] <= dl_hs[i-1];
        dl_vs[i] <= dl_vs[i-1];
      end
    end
  end

  assign de_d = dl_de[PIX_LAT-1];
  assign hs_d = dl_hs[PIX_LAT-1];
  assign vs_d = dl_vs[PIX_LAT-1];

  always_ff @(posedge i_pix_clk) begin
    if (!i_rst_n) begin
      o_de        <= 1'b0;
      rgb_q       <= '0;
      o_ctrl_ch0  <= {~V_POL, ~H_POL};
      o_underflow <= 1'b0;
    end else begin
      o_de       <= de_d;
      o_ctrl_ch0 <= ctrl_enc(vs_d, hs_d, V_POL, H_POL);
      if (!de_d)             rgb_q <= '0;
      else if (!i_rgb_valid) rgb_q <= UNDERFLOW_RGB;
      else                   rgb_q <= i_rgb;
      if (de_d && !i_rgb_valid) o_underflow <= 1'b1;
      else if (i_clr_underflow) o_underflow <= 1'b0;
    end
  end

  assign o_data_ch0 = rgb_q[7:0];
  assign o_data_ch1 = rgb_q[15:8];
  assign o_data_ch2 = rgb_q[23:16];
  assign o_ctrl_ch1 = 2'b00;
  assign o_ctrl_ch2 = 2'b00;

endmodule
